// File: rtl/sram_arbiter_2m.sv
// -----------------------------------------------------------------------------
// sram_arbiter_2m
//
// Two-master arbiter and sequencer in front of the 128-bit DE2 SRAM line
// controller. Master 0 is the data cache and master 1 is the instruction
// cache. One master's line transaction is latched and issued to the controller
// as a single-cycle read or write command. The arbiter then waits for the
// controller acknowledge and returns a one-cycle acknowledge, plus read data,
// to the granted master.
//
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
//   A request sampled in IDLE cycle C0 gives the command in C1.
//   With an 8-cycle controller, mem_ack_i arrives in C9 and the master ack
//   is high in C10. The next request is sampled in C11.
//
// Configuration macro:
//   SRAM_ARB_RR_EN  defined   : round-robin. On a tie, the master that did
//                               not win last time (grant_o) is granted.
//                   undefined : fixed priority. Master 0 wins every tie.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   m{0,1}_req_i                 request level, held until m{0,1}_ack_o
//   m{0,1}_we_i                  1 = line write, 0 = line read
//   m{0,1}_addr_i                line base address (16-bit word units)
//   m{0,1}_wdata_i               write line
//   m{0,1}_rdata_o               last line read for that master
//   m{0,1}_ack_o                 one-cycle completion pulse
//   mem_addr_o, mem_wdata_o      latched transaction, stable for its duration
//   mem_wren_o, mem_rden_o       one-cycle command pulses (ISSUE state)
//   mem_rdata_i, mem_ack_i       controller read line and completion pulse
//   grant_o                      master owning the current/last transaction
//   busy_o                       high whenever the FSM is not in IDLE
//   err_o                        sticky: mem_ack_i seen outside WAIT
// -----------------------------------------------------------------------------
module sram_arbiter_2m #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wren_o,
  output logic              mem_rden_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,

  output logic              grant_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                grant_reg;
  logic                wren_reg;
  logic                rden_reg;
  logic                busy_reg;
  logic                err_reg;
  logic [1:0]          ack_reg;

  logic [1:0]          req_vec;
  logic                win_next;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                rd_capture;

  assign req_vec = {m1_req_i, m0_req_i};

  // Winner selection. This value is only used when at least one request is
  // pending, so the all-idle case needs no special handling.
  always_comb begin
    win_next = 1'b0;
`ifdef SRAM_ARB_RR_EN
    if (req_vec == 2'b11) begin
      win_next = ~grant_reg;
    end else begin
      win_next = req_vec[1];
    end
`else
    win_next = ~req_vec[0];
`endif
  end

  assign win_we    = win_next ? m1_we_i    : m0_we_i;
  assign win_addr  = win_next ? m1_addr_i  : m0_addr_i;
  assign win_wdata = win_next ? m1_wdata_i : m0_wdata_i;

  // A read line is captured only on the acknowledge that ends a read in WAIT.
  // An acknowledge seen in any other state is flagged by err_o only.
  assign rd_capture = (state_reg == WAIT) && mem_ack_i && !we_reg;

  // Main sequencer. The command pulses and the master acks are registered
  // and default low, so each is high for exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      grant_reg <= 1'b0;
      wren_reg  <= 1'b0;
      rden_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
      ack_reg   <= 2'b00;
    end else begin
      wren_reg <= 1'b0;
      rden_reg <= 1'b0;
      ack_reg  <= 2'b00;

      if (mem_ack_i && (state_reg != WAIT)) begin
        err_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            grant_reg <= win_next;
            we_reg    <= win_we;
            addr_reg  <= win_addr;
            wdata_reg <= win_wdata;
            // The command is raised together with the move to ISSUE, so it
            // is visible throughout the ISSUE cycle.
            wren_reg  <= win_we;
            rden_reg  <= ~win_we;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (mem_ack_i) begin
            ack_reg[grant_reg] <= 1'b1;
            state_reg          <= RESP;
          end
        end
        RESP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Per-master read-line holding registers. A master's line changes only when
  // a read of its own completes. Otherwise it keeps the last captured line.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rdata_reg <= '0;
        end else if (rd_capture && (grant_reg == (gi == 1))) begin
          rdata_reg <= mem_rdata_i;
        end
      end
    end
  endgenerate

  assign m0_rdata_o  = g_master[0].rdata_reg;
  assign m1_rdata_o  = g_master[1].rdata_reg;
  assign m0_ack_o    = ack_reg[0];
  assign m1_ack_o    = ack_reg[1];

  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign mem_wren_o  = wren_reg;
  assign mem_rden_o  = rden_reg;

  assign grant_o     = grant_reg;
  assign busy_o      = busy_reg;
  assign err_o       = err_reg;

endmodule

// File: doc/sram_arbiter_2m.md
# sram_arbiter_2m

Two-master arbiter and sequencer in front of the 128-bit DE2 SRAM controller. It shares the single SRAM line port between the data cache (master 0) and the instruction cache (master 1). It latches one requester's line transaction, issues it to the controller as a single-cycle command, and waits for the controller's acknowledge. It then returns read data and a one-cycle acknowledge to the granted master.

## Interface
Parameters:
- ADDR_W, 32, address width on master and memory sides.
- DATA_W, 128, line width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_req_i  in  1  master 0 (dcache) request level, held until m0_ack_o.
- m0_we_i  in  1  1 = line write, 0 = line read.
- m0_addr_i  in  ADDR_W  line base address (16-bit word units).
- m0_wdata_i  in  DATA_W  write line.
- m0_rdata_o  out  DATA_W  read line, valid while m0_ack_o = 1.
- m0_ack_o  out  1  one-cycle completion pulse.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ack_o: the same set for master 1 (icache).
- mem_addr_o  out  ADDR_W  to controller address.
- mem_wdata_o  out  DATA_W  to controller write data.
- mem_wren_o  out  1  write command, one-cycle pulse.
- mem_rden_o  out  1  read command, one-cycle pulse.
- mem_rdata_i  in  DATA_W  controller read line.
- mem_ack_i  in  1  controller completion pulse.
- grant_o  out  1  index of the master owning the current or last transaction.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky: mem_ack_i seen outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any request is pending, select a winner.
  - Latch the winner's we, addr and wdata into internal registers, set grant_o, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - Drive exactly one of mem_wren_o or mem_rden_o high for this single cycle, chosen by the latched we.
  - Go to WAIT.
- **WAIT:**
  - mem_wren_o = mem_rden_o = 0. This guarantees the controller does not restart in its ack state.
  - On mem_ack_i: capture mem_rdata_i (reads only) and go to RESP.
- **RESP:**
  - Pulse m{grant}_ack_o. m{grant}_rdata_o shows the captured line.
  - Go to IDLE.
- mem_addr_o and mem_wdata_o are driven from the latched registers in all states, so they stay stable for the whole transaction.
- Requests are never preempted. A request arriving during busy waits until IDLE.
- A master holding req_i high in the cycle after its ack is treated as a new request.
- The acknowledge of the non-granted master stays at 0. Its rdata_o holds its last captured line.
- err_o is set by mem_ack_i in IDLE, ISSUE or RESP. It is cleared only by reset. The FSM ignores that acknowledge.
- Master-side input changes after latching have no effect on the current transaction.

## Timing
- Reset values: state = IDLE; all *_o = 0, including rdata, grant_o, busy_o, err_o and the latched registers.
- Reset asserted mid-transaction returns to IDLE immediately. Any pending master ack is lost and the mem command is dropped.
- Let cycle C0 be the IDLE cycle in which the request is sampled:
  - ISSUE at C1.
  - The controller runs its 8-word sequence and pulses mem_ack_i at C9.
  - RESP at C10: m_ack_o = 1.
  - Total 10 cycles, for both read and write.
- Back-to-back throughput: IDLE at C11 samples the next request, so the period is 11 cycles per line.
- Latency from mem_ack_i to m_ack_o is exactly 1 cycle, independent of controller latency.

## Configuration
- `SRAM_ARB_RR_EN` **defined:** round-robin arbitration.
  - On simultaneous requests in IDLE, grant the master not equal to grant_o (the last winner).
  - A lone requester always wins.
- **Undefined:** fixed priority. Master 0 wins every simultaneous request, so master 1 can starve.

## Test plan
- **Single read:** m0 read, addr = 0x100, SRAM model holding 0x0123...CDEF.
  - mem_rden_o is pulsed for 1 cycle at C1 with mem_addr_o = 0x100.
  - m0_ack_o is high at C10 with m0_rdata_o = the model line.
  - mem_wren_o stays 0 throughout.
- **Single write:** m1 write, addr = 0x200, wdata = 128'hA5A5…
  - mem_wren_o is pulsed once; mem_wdata_o stays stable until ack.
  - m1_ack_o is high at C10. A readback of 0x200 returns the same line.
- **Simultaneous m0 and m1 reads, held continuously:**
  - With `SRAM_ARB_RR_EN` defined, grants alternate 0,1,0,1.
  - Without it, grants are 0,0,0…
- **Request arrives while busy:** m1 requests at C3 of an m0 transaction.
  - m1 is granted at C11 and acked at C21.
  - No second mem command is issued before C12.
- **Reset mid-WAIT:** assert rst_i at C5.
  - All outputs read 0 in the same cycle and the state is IDLE.
  - After release, a new m0 read completes normally.
- **Spurious acknowledge:** mem_ack_i pulsed in IDLE.
  - err_o = 1 and stays set.
  - No m_ack_o is generated and the FSM does not leave IDLE.
